// File: rtl/hex_event_drain_if.sv
// Output stream of the event drain: 64-bit words with valid/ready handshake
// and a last marker on the per-frame trailer word.
interface hex_event_drain_if;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;

  // Drain side drives the word, host side drives ready.
  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/hex_event_drain.sv
// Event drain: after each frame_done, streams mem[0..N-1] followed by a
// trailer {F00D, frame id, N} over a backpressure-safe valid/ready stream.
// DEPTH is expected to be a power of two so the read index slices cleanly.
module hex_event_drain #(
  parameter int DEPTH = 256,
  parameter int IDW   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_done_i,
  input  logic [63:0]         mem_i [DEPTH],
  input  logic [31:0]         write_count_i,
  hex_event_drain_if.master   out_if,
  output logic                busy_o,
  output logic [IDW-1:0]      frame_id_o,
  output logic [7:0]          overrun_count_o
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, READ, TRAILER} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic             valid_q, valid_d;
  logic [63:0]      data_q, data_d;
  logic             last_q, last_d;
  logic [IDW-1:0]   fid_q, fid_d;
  logic [7:0]       ovr_q, ovr_d;

  logic             load;
  logic             xfer;
  logic [CNT_W-1:0] n_clamp;

  function automatic logic [63:0] trailer_word(logic [IDW-1:0] fid, logic [CNT_W-1:0] n);
    return {16'hF00D, 16'(fid), 32'(n)};
  endfunction

  // Output register may take a new word when empty or being emptied this cycle.
  assign load    = !valid_q || out_if.out_ready;
  assign xfer    = valid_q && out_if.out_ready;
  assign n_clamp = (write_count_i > 32'(DEPTH)) ? CNT_W'(DEPTH) : write_count_i[CNT_W-1:0];

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      fid_q   <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      fid_q   <= fid_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state: frame start, word sequencing, trailer and overrun counting.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    fid_d   = fid_q;
    ovr_d   = ovr_q;

    case (state_q)
      IDLE: begin
        if (frame_done_i) begin
          n_d     = n_clamp;
          valid_d = 1'b1;
          if (n_clamp != '0) begin
            data_d  = mem_i[0];
            last_d  = 1'b0;
            idx_d   = CNT_W'(1);
            state_d = READ;
          end else begin
            data_d  = trailer_word(fid_q, '0);
            last_d  = 1'b1;
            state_d = TRAILER;
          end
        end
      end
      READ: begin
        if (load) begin
          valid_d = 1'b1;
          if (idx_q < n_q) begin
            // idx_q < n_q <= DEPTH keeps the read in range.
            data_d = mem_i[idx_q[IDX_W-1:0]];
            idx_d  = idx_q + CNT_W'(1);
          end else begin
            data_d  = trailer_word(fid_q, n_q);
            last_d  = 1'b1;
            state_d = TRAILER;
          end
        end
      end
      TRAILER: begin
        if (xfer) begin
          fid_d   = fid_q + IDW'(1);
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A frame_done outside IDLE is dropped and counted (saturating).
    if (frame_done_i && state_q != IDLE && ovr_q != 8'hFF)
      ovr_d = ovr_q + 8'd1;
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_last  = last_q;
  assign busy_o           = (state_q != IDLE);
  assign frame_id_o       = fid_q;
  assign overrun_count_o  = ovr_q;
endmodule

// File: tb/tb_hex_event_drain.sv
// Directed bench for hex_event_drain; IDW reduced to 4 so id wrap is reachable.
module tb_hex_event_drain;
  localparam int DEPTH = 256;
  localparam int IDW   = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           frame_done;
  logic [63:0]    mem [DEPTH];
  logic [31:0]    write_count;
  logic           busy;
  logic [IDW-1:0] frame_id;
  logic [7:0]     overrun;

  int checks = 0;
  int errors = 0;

  hex_event_drain_if bus ();

  hex_event_drain #(.DEPTH(DEPTH), .IDW(IDW)) dut (
    .clk             (clk),
    .reset           (reset),
    .frame_done_i    (frame_done),
    .mem_i           (mem),
    .write_count_i   (write_count),
    .out_if          (bus.master),
    .busy_o          (busy),
    .frame_id_o      (frame_id),
    .overrun_count_o (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] trl(input int fid, input int n);
    return {16'hF00D, 16'(fid), 32'(n)};
  endfunction

  function automatic logic [63:0] pat(input int i);
    return {32'hABCD_0000, 32'(i)};
  endfunction

  initial begin
    logic [63:0] expw;
    int k;
    bit done;

    reset = 1'b1; frame_done = 1'b0; write_count = '0; bus.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = pat(i);
    tick; tick;
    reset = 1'b0;

    // Reset state
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data",  bus.out_data, 64'd0);
    chk("rst_last",  64'(bus.out_last), 64'd0);
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_fid",   64'(frame_id), 64'd0);
    chk("rst_ovr",   64'(overrun), 64'd0);

    // 1: three events back to back, then trailer
    mem[0] = 64'h1111_AAAA_0000_000A;
    mem[1] = 64'h2222_BBBB_0000_000B;
    mem[2] = 64'h3333_CCCC_0000_000C;
    write_count = 32'd3;
    frame_done = 1'b1; tick; frame_done = 1'b0;
    chk("t1_v0", 64'(bus.out_valid), 64'd1);
    chk("t1_A", bus.out_data, 64'h1111_AAAA_0000_000A);
    chk("t1_busy", 64'(busy), 64'd1);
    tick; chk("t1_B", bus.out_data, 64'h2222_BBBB_0000_000B);
    chk("t1_Blast", 64'(bus.out_last), 64'd0);
    tick; chk("t1_C", bus.out_data, 64'h3333_CCCC_0000_000C);
    tick; chk("t1_trl", bus.out_data, 64'hF00D_0000_0000_0003);
    chk("t1_last", 64'(bus.out_last), 64'd1);
    tick; chk("t1_vdone", 64'(bus.out_valid), 64'd0);
    chk("t1_fid", 64'(frame_id), 64'd1);
    chk("t1_idle", 64'(busy), 64'd0);

    // 2: empty frame gives only the trailer, busy for one cycle
    write_count = 32'd0;
    frame_done = 1'b1; tick; frame_done = 1'b0;
    chk("t2_v", 64'(bus.out_valid), 64'd1);
    chk("t2_trl", bus.out_data, trl(1, 0));
    chk("t2_last", 64'(bus.out_last), 64'd1);
    chk("t2_busy", 64'(busy), 64'd1);
    tick;
    chk("t2_busy_off", 64'(busy), 64'd0);
    chk("t2_v_off", 64'(bus.out_valid), 64'd0);

    // 3: write_count beyond DEPTH is clamped
    for (int i = 0; i < DEPTH; i++) mem[i] = pat(i);
    write_count = 32'd300;
    frame_done = 1'b1; tick; frame_done = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("t3_w%0d", i), bus.out_data, pat(i));
      tick;
    end
    chk("t3_trl", bus.out_data, trl(2, 256));
    chk("t3_last", 64'(bus.out_last), 64'd1);
    tick;
    chk("t3_fid", 64'(frame_id), 64'd3);

    // 4: backpressure with ready pattern 1,0,0,1
    write_count = 32'd4;
    bus.out_ready = 1'b0;
    frame_done = 1'b1; tick; frame_done = 1'b0;
    k = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      expw = (k < 4) ? pat(k) : trl(3, 4);
      chk($sformatf("t4_v_c%0d", c), 64'(bus.out_valid), 64'd1);
      chk($sformatf("t4_d_c%0d", c), bus.out_data, expw);
      chk($sformatf("t4_l_c%0d", c), 64'(bus.out_last), 64'(k == 4));
      bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
      tick;
      if (bus.out_ready) begin
        if (k == 4) done = 1'b1;
        else k++;
      end
    end
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_v_off", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1'b1;

    // 5: frame_done pulses during a drain are counted, frame unaffected
    write_count = 32'd5;
    frame_done = 1'b1; tick;
    for (int w = 0; w < 6; w++) begin
      expw = (w < 5) ? pat(w) : trl(4, 5);
      chk($sformatf("t5_w%0d", w), bus.out_data, expw);
      frame_done = (w >= 1 && w <= 3);
      tick;
    end
    frame_done = 1'b0;
    chk("t5_ovr", 64'(overrun), 64'd3);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_fid", 64'(frame_id), 64'd5);

    // 6: reset after two accepted words aborts the frame
    frame_done = 1'b1; tick; frame_done = 1'b0;
    tick; tick;
    chk("t6_mid", bus.out_data, pat(2));
    reset = 1'b1; tick; reset = 1'b0;
    chk("t6_v", 64'(bus.out_valid), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_fid", 64'(frame_id), 64'd0);
    tick;
    chk("t6_stay", 64'(busy), 64'd0);

    // 7: successive frames advance the id, 16 frames wrap it
    write_count = 32'd1;
    frame_done = 1'b1; tick; frame_done = 1'b0;
    chk("t7_w0", bus.out_data, pat(0));
    tick; chk("t7_trl0", bus.out_data, trl(0, 1));
    tick;
    frame_done = 1'b1; tick; frame_done = 1'b0;
    tick; chk("t7_trl1", bus.out_data, trl(1, 1));
    tick;
    write_count = 32'd0;
    for (int f = 2; f < 16; f++) begin
      frame_done = 1'b1; tick; frame_done = 1'b0;
      if (f == 15) chk("t7_trl15", bus.out_data, trl(15, 0));
      tick;
    end
    chk("t7_wrap", 64'(frame_id), 64'd0);
    chk("t7_ovr", 64'(overrun), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
